// File: rtl/exc_commit_ctrl_pkg.sv
// Shared constants for the exception/return commit controller: cause codes,
// exception flag bit positions and FSM state encoding.
package exc_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [8:0] ESUB_INT  = 9'd0;
    localparam logic [8:0] ESUB_ADEF = 9'd0;
    localparam logic [8:0] ESUB_ALE  = 9'd0;
    localparam logic [8:0] ESUB_SYS  = 9'd0;
    localparam logic [8:0] ESUB_BRK  = 9'd0;
    localparam logic [8:0] ESUB_INE  = 9'd0;

    localparam int unsigned EXC_ADEF = 0;
    localparam int unsigned EXC_INE  = 1;
    localparam int unsigned EXC_SYS  = 2;
    localparam int unsigned EXC_BRK  = 3;
    localparam int unsigned EXC_ALE  = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE     = 2'd0;
    localparam state_t S_COMMIT   = 2'd1;
    localparam state_t S_REDIRECT = 2'd2;
    localparam state_t S_DRAIN    = 2'd3;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// WB/CSR/pre-IF signal bundle of the commit controller; slave is the controller side.
interface exc_commit_ctrl_if;

    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_exc;
    logic        wb_ertn;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] er_entry;
    logic        wb_ready;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_ex_pc;
    logic        ertn_flush;
    logic        pipe_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport slave (
        input  wb_valid, wb_pc, wb_exc, wb_ertn, has_int, ex_entry, er_entry, redirect_ready,
        output wb_ready, wb_ex, wb_ecode, wb_esubcode, wb_ex_pc, ertn_flush, pipe_flush,
               redirect_valid, redirect_pc
    );

    modport master (
        output wb_valid, wb_pc, wb_exc, wb_ertn, has_int, ex_entry, er_entry, redirect_ready,
        input  wb_ready, wb_ex, wb_ecode, wb_esubcode, wb_ex_pc, ertn_flush, pipe_flush,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Combinational cause prioritiser: INT > ADEF > INE > SYS > BRK > ALE > ERTN.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       i_has_int,
    input  logic [4:0] i_wb_exc,
    input  logic       i_wb_ertn,
    output logic       o_is_ex,
    output logic       o_is_ertn,
    output logic [5:0] o_ecode,
    output logic [8:0] o_esubcode
);

    always_comb begin
        o_is_ex   = i_has_int | (|i_wb_exc);
        o_is_ertn = i_wb_ertn & ~o_is_ex;
        o_ecode    = ECODE_INT;
        o_esubcode = ESUB_INT;
        if (i_has_int) begin
            o_ecode    = ECODE_INT;
            o_esubcode = ESUB_INT;
        end else if (i_wb_exc[EXC_ADEF]) begin
            o_ecode    = ECODE_ADEF;
            o_esubcode = ESUB_ADEF;
        end else if (i_wb_exc[EXC_INE]) begin
            o_ecode    = ECODE_INE;
            o_esubcode = ESUB_INE;
        end else if (i_wb_exc[EXC_SYS]) begin
            o_ecode    = ECODE_SYS;
            o_esubcode = ESUB_SYS;
        end else if (i_wb_exc[EXC_BRK]) begin
            o_ecode    = ECODE_BRK;
            o_esubcode = ESUB_BRK;
        end else if (i_wb_exc[EXC_ALE]) begin
            o_ecode    = ECODE_ALE;
            o_esubcode = ESUB_ALE;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/ertn commit sequencer: CSR pulse, pipeline flush, redirect handshake, drain.
module exc_commit_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned DRAIN_CYC = 2
) (
    input logic              clk,
    input logic              reset,
    exc_commit_ctrl_if.slave bus
);

    logic        w_is_ex;
    logic        w_is_ertn;
    logic [5:0]  w_ecode;
    logic [8:0]  w_esubcode;
    logic        w_trig;
    logic        w_handshake;

    state_t      r_state;
    logic        r_is_ex;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic [31:0] r_ex_pc;
    logic [31:0] r_redirect_pc;
    logic [3:0]  r_cnt;

    exc_prio_enc u_prio_enc (
        .i_has_int  (bus.has_int),
        .i_wb_exc   (bus.wb_exc),
        .i_wb_ertn  (bus.wb_ertn),
        .o_is_ex    (w_is_ex),
        .o_is_ertn  (w_is_ertn),
        .o_ecode    (w_ecode),
        .o_esubcode (w_esubcode)
    );

    assign w_trig      = bus.wb_valid & (w_is_ex | w_is_ertn);
    assign w_handshake = (r_state == S_REDIRECT) & bus.redirect_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_is_ex       <= 1'b0;
            r_ecode       <= 6'd0;
            r_esubcode    <= 9'd0;
            r_ex_pc       <= 32'd0;
            r_redirect_pc <= 32'd0;
            r_cnt         <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_is_ex <= w_is_ex;
                        r_ex_pc <= bus.wb_pc;
                        // Ecode only moves for real exceptions; ertn leaves the last value.
                        if (w_is_ex) begin
                            r_ecode    <= w_ecode;
                            r_esubcode <= w_esubcode;
                        end
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_redirect_pc <= r_is_ex ? bus.ex_entry : bus.er_entry;
                    r_state       <= S_REDIRECT;
                end
                S_REDIRECT: begin
                    if (w_handshake) begin
                        r_cnt   <= 4'(DRAIN_CYC - 1);
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.wb_ready       = (r_state == S_IDLE);
    assign bus.wb_ex          = (r_state == S_COMMIT) & r_is_ex;
    assign bus.ertn_flush     = (r_state == S_COMMIT) & ~r_is_ex;
    assign bus.wb_ecode       = r_ecode;
    assign bus.wb_esubcode    = r_esubcode;
    assign bus.wb_ex_pc       = r_ex_pc;
    assign bus.pipe_flush     = (r_state != S_IDLE);
    assign bus.redirect_valid = (r_state == S_REDIRECT);
    assign bus.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl with DRAIN_CYC = 2.
module tb_exc_commit_ctrl;

    localparam int unsigned DC = 2;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   n;

    exc_commit_ctrl_if bus ();

    exc_commit_ctrl #(.DRAIN_CYC(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_wb();
        bus.wb_valid = 1'b0;
        bus.wb_exc   = 5'd0;
        bus.wb_ertn  = 1'b0;
        bus.has_int  = 1'b0;
    endtask

    // Ticks until wb_ready returns, bounded, then checks the tick count.
    task automatic to_idle(input string tag, input int exp_ticks);
        n = 0;
        while (bus.wb_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_ticks));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clear_wb();
        bus.wb_pc          = 32'd0;
        bus.ex_entry       = 32'd0;
        bus.er_entry       = 32'd0;
        bus.redirect_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", 32'(bus.wb_ready), 32'd1);
        chk("rst_flush", 32'(bus.pipe_flush), 32'd0);
        chk("rst_rv", 32'(bus.redirect_valid), 32'd0);
        chk("rst_rpc", bus.redirect_pc, 32'd0);
        chk("rst_ecode", 32'(bus.wb_ecode), 32'd0);

        // SYS exception, full timeline
        bus.wb_valid = 1'b1; bus.wb_exc = 5'b00100; bus.wb_pc = 32'h1C000010;
        bus.ex_entry = 32'h1C008000; bus.redirect_ready = 1'b1;
        tick();
        clear_wb();
        chk("sys_wb_ex", 32'(bus.wb_ex), 32'd1);
        chk("sys_ertn", 32'(bus.ertn_flush), 32'd0);
        chk("sys_ecode", 32'(bus.wb_ecode), 32'h0B);
        chk("sys_esub", 32'(bus.wb_esubcode), 32'd0);
        chk("sys_expc", bus.wb_ex_pc, 32'h1C000010);
        chk("sys_flush_c", 32'(bus.pipe_flush), 32'd1);
        chk("sys_ready_c", 32'(bus.wb_ready), 32'd0);
        tick();
        chk("sys_rv", 32'(bus.redirect_valid), 32'd1);
        chk("sys_rpc", bus.redirect_pc, 32'h1C008000);
        chk("sys_wb_ex_off", 32'(bus.wb_ex), 32'd0);
        tick();
        chk("sys_drain_rv", 32'(bus.redirect_valid), 32'd0);
        chk("sys_drain_flush", 32'(bus.pipe_flush), 32'd1);
        tick();
        chk("sys_drain2_ready", 32'(bus.wb_ready), 32'd0);
        chk("sys_drain2_flush", 32'(bus.pipe_flush), 32'd1);
        tick();
        chk("sys_idle_ready", 32'(bus.wb_ready), 32'd1);
        chk("sys_idle_flush", 32'(bus.pipe_flush), 32'd0);
        chk("sys_hold_ecode", 32'(bus.wb_ecode), 32'h0B);

        // ertn
        bus.wb_valid = 1'b1; bus.wb_ertn = 1'b1; bus.wb_pc = 32'h1C000100;
        bus.er_entry = 32'h1C000200;
        tick();
        clear_wb();
        chk("ertn_flush", 32'(bus.ertn_flush), 32'd1);
        chk("ertn_wb_ex", 32'(bus.wb_ex), 32'd0);
        tick();
        chk("ertn_rpc", bus.redirect_pc, 32'h1C000200);
        chk("ertn_pulse_off", 32'(bus.ertn_flush), 32'd0);
        to_idle("ertn_drain", DC + 1);

        // INT beats ALE/ADEF and suppresses ertn
        bus.wb_valid = 1'b1; bus.has_int = 1'b1; bus.wb_exc = 5'b10001; bus.wb_ertn = 1'b1;
        bus.wb_pc = 32'h1C000020;
        tick();
        clear_wb();
        chk("int_wb_ex", 32'(bus.wb_ex), 32'd1);
        chk("int_ecode", 32'(bus.wb_ecode), 32'h00);
        chk("int_no_ertn", 32'(bus.ertn_flush), 32'd0);
        tick();
        chk("int_no_ertn_r", 32'(bus.ertn_flush), 32'd0);
        to_idle("int_drain", DC + 1);

        // INE beats ALE
        bus.wb_valid = 1'b1; bus.wb_exc = 5'b10010; bus.wb_pc = 32'h1C000030;
        tick();
        clear_wb();
        chk("ine_ecode", 32'(bus.wb_ecode), 32'h0D);
        chk("ine_wb_ex", 32'(bus.wb_ex), 32'd1);
        to_idle("ine_drain", DC + 2);

        // Interrupt waits for a valid instruction
        bus.has_int = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("int_wait_ready", 32'(bus.wb_ready), 32'd1);
            chk("int_wait_flush", 32'(bus.pipe_flush), 32'd0);
        end
        bus.wb_valid = 1'b1; bus.wb_pc = 32'h1C000040;
        tick();
        clear_wb();
        chk("int_late_ex", 32'(bus.wb_ex), 32'd1);
        chk("int_late_ecode", 32'(bus.wb_ecode), 32'h00);
        chk("int_late_expc", bus.wb_ex_pc, 32'h1C000040);
        to_idle("int_late_drain", DC + 2);

        // Redirect back-pressure
        bus.redirect_ready = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_exc = 5'b01000; bus.wb_pc = 32'h1C000050;
        bus.ex_entry = 32'h1C008100;
        tick();
        clear_wb();
        chk("bp_ecode", 32'(bus.wb_ecode), 32'h0C);
        tick();
        bus.ex_entry = 32'hDEADBEEF;
        bus.wb_valid = 1'b1; bus.wb_exc = 5'b00001;
        chk("bp_rv0", 32'(bus.redirect_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_rv_hold", 32'(bus.redirect_valid), 32'd1);
            chk("bp_rpc_hold", bus.redirect_pc, 32'h1C008100);
        end
        clear_wb();
        bus.redirect_ready = 1'b1;
        tick();
        chk("bp_drain_rv", 32'(bus.redirect_valid), 32'd0);
        chk("bp_drain_flush", 32'(bus.pipe_flush), 32'd1);
        chk("bp_ecode_hold", 32'(bus.wb_ecode), 32'h0C);
        to_idle("bp_drain", DC);

        // Reset in REDIRECT drops the redirect
        bus.redirect_ready = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_exc = 5'b00100; bus.wb_pc = 32'h1C000060;
        bus.ex_entry = 32'h1C008200;
        tick();
        clear_wb();
        tick();
        chk("rr_pre_rv", 32'(bus.redirect_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_ready", 32'(bus.wb_ready), 32'd1);
        chk("rr_rv", 32'(bus.redirect_valid), 32'd0);
        chk("rr_flush", 32'(bus.pipe_flush), 32'd0);
        chk("rr_wb_ex", 32'(bus.wb_ex), 32'd0);
        chk("rr_ecode", 32'(bus.wb_ecode), 32'd0);
        chk("rr_expc", bus.wb_ex_pc, 32'd0);
        chk("rr_rpc", bus.redirect_pc, 32'd0);
        bus.redirect_ready = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_exc = 5'b00100; bus.wb_pc = 32'h1C000080;
        bus.ex_entry = 32'h1C008300;
        tick();
        clear_wb();
        chk("rr2_wb_ex", 32'(bus.wb_ex), 32'd1);
        chk("rr2_ecode", 32'(bus.wb_ecode), 32'h0B);
        chk("rr2_expc", bus.wb_ex_pc, 32'h1C000080);
        tick();
        chk("rr2_rpc", bus.redirect_pc, 32'h1C008300);
        to_idle("rr2_drain", DC + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
